// File: rtl/riscv_32f_fp_issue_ctrl.sv
// Single-outstanding issue controller between FP decode and the pipelined RV32F ALU.
// Registers one op onto the ALU inputs, waits its latency, captures the result for writeback.
module riscv_32f_fp_issue_ctrl #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned LAT_W = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_in0_i,
    input  logic [31:0]      req_in1_i,
    input  logic [31:0]      req_in2_i,
    input  logic [15:0]      req_encoding_i,
    input  logic [4:0]       req_func5_i,
    input  logic [4:0]       req_fsrc2_i,
    input  logic [2:0]       req_rm_i,
    input  logic [LAT_W-1:0] req_lat_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      alu_in0_o,
    output logic [31:0]      alu_in1_o,
    output logic [31:0]      alu_in2_o,
    output logic [15:0]      alu_encoding_o,
    output logic [4:0]       alu_func5_o,
    output logic [4:0]       alu_fsrc2_o,
    output logic [2:0]       alu_rm_o,
    input  logic [31:0]      alu_result_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    input  logic             flush_i,
    output logic             busy_o,
    output logic [31:0]      op_count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic             accept;

    assign req_ready_o  = !flush_i && ((state == IDLE) || ((state == DONE) && resp_ready_i));
    assign accept       = req_valid_i && req_ready_o;
    assign resp_valid_o = (state == DONE);
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state          <= IDLE;
            cnt            <= '0;
            alu_in0_o      <= '0;
            alu_in1_o      <= '0;
            alu_in2_o      <= '0;
            alu_encoding_o <= '0;
            alu_func5_o    <= '0;
            alu_fsrc2_o    <= '0;
            alu_rm_o       <= '0;
            resp_data_o    <= '0;
            resp_tag_o     <= '0;
            op_count_o     <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        resp_data_o <= alu_result_i;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        op_count_o <= op_count_o + 32'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Accept is only possible from IDLE or a completing DONE; it overrides the case above.
            if (accept) begin
                alu_in0_o      <= req_in0_i;
                alu_in1_o      <= req_in1_i;
                alu_in2_o      <= req_in2_i;
                alu_encoding_o <= req_encoding_i;
                alu_func5_o    <= req_func5_i;
                alu_fsrc2_o    <= req_fsrc2_i;
                alu_rm_o       <= req_rm_i;
                resp_tag_o     <= req_tag_i;
                cnt            <= req_lat_i;
                state          <= EXEC;
            end
        end
    end

endmodule

// File: tb/tb_riscv_32f_fp_issue_ctrl.sv
// Bench for riscv_32f_fp_issue_ctrl: vector table with scoreboard, plus backpressure,
// flush and asynchronous-reset sequences against a simple stand-in ALU.
module tb_riscv_32f_fp_issue_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_in0_i, req_in1_i, req_in2_i;
    logic [15:0] req_encoding_i;
    logic [4:0]  req_func5_i, req_fsrc2_i;
    logic [2:0]  req_rm_i;
    logic [3:0]  req_lat_i;
    logic [4:0]  req_tag_i;
    logic [31:0] alu_in0_o, alu_in1_o, alu_in2_o;
    logic [15:0] alu_encoding_o;
    logic [4:0]  alu_func5_o, alu_fsrc2_o;
    logic [2:0]  alu_rm_o;
    logic [31:0] alu_result_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_tag_o;
    logic        flush_i;
    logic        busy_o;
    logic [31:0] op_count_o;

    riscv_32f_fp_issue_ctrl #(.TAG_W(5), .LAT_W(4)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_in0_i(req_in0_i), .req_in1_i(req_in1_i), .req_in2_i(req_in2_i),
        .req_encoding_i(req_encoding_i), .req_func5_i(req_func5_i),
        .req_fsrc2_i(req_fsrc2_i), .req_rm_i(req_rm_i),
        .req_lat_i(req_lat_i), .req_tag_i(req_tag_i),
        .alu_in0_o(alu_in0_o), .alu_in1_o(alu_in1_o), .alu_in2_o(alu_in2_o),
        .alu_encoding_o(alu_encoding_o), .alu_func5_o(alu_func5_o),
        .alu_fsrc2_o(alu_fsrc2_o), .alu_rm_o(alu_rm_o),
        .alu_result_i(alu_result_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o),
        .flush_i(flush_i), .busy_o(busy_o), .op_count_o(op_count_o)
    );

    always #5 clock_i = ~clock_i;

    // Stand-in ALU: sign injection (func5=4), divide-by-1.0 (func5=3), otherwise XOR.
    always_comb begin
        alu_result_i = alu_in0_o ^ alu_in1_o;
        if (alu_func5_o == 5'd4) begin
            case (alu_rm_o)
                3'd0:    alu_result_i = {alu_in1_o[31], alu_in0_o[30:0]};
                3'd1:    alu_result_i = {~alu_in1_o[31], alu_in0_o[30:0]};
                default: alu_result_i = {alu_in0_o[31] ^ alu_in1_o[31], alu_in0_o[30:0]};
            endcase
        end else if (alu_func5_o == 5'd3) begin
            alu_result_i = (alu_in1_o == 32'h3F80_0000) ? alu_in0_o : 32'h7FC0_0000;
        end
    end

    typedef struct {
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [15:0] enc;
        logic [4:0]  func5;
        logic [4:0]  fsrc2;
        logic [2:0]  rm;
        logic [3:0]  lat;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic drive_req(input vec_t v);
        req_in0_i      = v.in0;
        req_in1_i      = v.in1;
        req_in2_i      = v.in2;
        req_encoding_i = v.enc;
        req_func5_i    = v.func5;
        req_fsrc2_i    = v.fsrc2;
        req_rm_i       = v.rm;
        req_lat_i      = v.lat;
        req_tag_i      = v.tag;
    endtask

    task automatic sb_push(input vec_t v);
        exp_t e;
        e.data = v.exp;
        e.tag  = v.tag;
        sb.push_back(e);
    endtask

    task automatic sb_resp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("resp_data", resp_data_o, e.data);
            chk("resp_tag", {27'd0, resp_tag_o}, {27'd0, e.tag});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        drive_req(v);
        req_valid_i  = 1'b1;
        resp_ready_i = 1'b1;
        #1 chk("ready_at_accept", {31'd0, req_ready_o}, 32'd1);
        sb_push(v);
        cyc();
        req_valid_i = 1'b0;
        k = 1;
        while (!resp_valid_o && k < 40) begin
            chk("busy_exec", {31'd0, busy_o}, 32'd1);
            chk("ready_exec", {31'd0, req_ready_o}, 32'd0);
            chk("alu_in0_hold", alu_in0_o, v.in0);
            chk("alu_in1_hold", alu_in1_o, v.in1);
            chk("alu_func5_hold", {27'd0, alu_func5_o}, {27'd0, v.func5});
            cyc();
            k++;
        end
        chk("resp_latency", k, 32'(v.lat) + 32'd2);
        chk("alu_in2", alu_in2_o, v.in2);
        chk("alu_encoding", {16'd0, alu_encoding_o}, {16'd0, v.enc});
        chk("alu_fsrc2", {27'd0, alu_fsrc2_o}, {27'd0, v.fsrc2});
        chk("alu_rm", {29'd0, alu_rm_o}, {29'd0, v.rm});
        if (resp_valid_o) begin
            sb_resp();
            cyc();
            exp_count++;
        end
        chk("op_count", op_count_o, exp_count);
        chk("busy_after", {31'd0, busy_o}, 32'd0);
        chk("valid_after", {31'd0, resp_valid_o}, 32'd0);
    endtask

    initial begin
        vec_t vb, vc, vf, vg, vm;
        int   k;
        int   seen;

        vecs[0] = '{32'h3F80_0000, 32'h8000_0000, 32'h0000_0001, 16'h0010, 5'd4, 5'd0, 3'd0, 4'd0,  5'd7,  32'hBF80_0000};
        vecs[1] = '{32'h4040_0000, 32'h3F80_0000, 32'h0000_0002, 16'h0020, 5'd3, 5'd1, 3'd1, 4'd10, 5'd3,  32'h4040_0000};
        vecs[2] = '{32'h3F80_0000, 32'h8000_0000, 32'hA5A5_A5A5, 16'h0030, 5'd4, 5'd2, 3'd1, 4'd1,  5'd12, 32'h3F80_0000};
        vecs[3] = '{32'hC000_0000, 32'h8000_0000, 32'h5A5A_5A5A, 16'hFFFF, 5'd4, 5'd31, 3'd2, 4'd3, 5'd31, 32'h4000_0000};
        vecs[4] = '{32'h1234_5678, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h8001, 5'd0, 5'd5, 3'd7, 4'd15, 5'd0,  32'hEDCB_5678};

        reset_i      = 1'b0;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b0;
        flush_i      = 1'b0;
        drive_req(vecs[0]);
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        #1;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_op_count", op_count_o, 32'd0);
        chk("rst_alu_in0", alu_in0_o, 32'd0);
        @(negedge clock_i);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Writeback backpressure, then back-to-back issue on the releasing edge.
        vb = '{32'h4000_0000, 32'h8000_0000, 32'd0, 16'h0040, 5'd4, 5'd0, 3'd0, 4'd2, 5'd9,  32'hC000_0000};
        vc = '{32'h0000_FFFF, 32'h0F0F_0000, 32'd0, 16'h0050, 5'd0, 5'd0, 3'd0, 4'd0, 5'd21, 32'h0F0F_FFFF};
        drive_req(vb);
        req_valid_i  = 1'b1;
        resp_ready_i = 1'b0;
        sb_push(vb);
        cyc();
        req_valid_i = 1'b0;
        k = 1;
        while (!resp_valid_o && k < 40) begin
            cyc();
            k++;
        end
        chk("bp_latency", k, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data_hold", resp_data_o, 32'hC000_0000);
            chk("bp_tag_hold", {27'd0, resp_tag_o}, 32'd9);
            chk("bp_ready", {31'd0, req_ready_o}, 32'd0);
            chk("bp_valid", {31'd0, resp_valid_o}, 32'd1);
            cyc();
        end
        chk("bp_op_count", op_count_o, exp_count);
        drive_req(vc);
        req_valid_i  = 1'b1;
        resp_ready_i = 1'b1;
        #1 chk("b2b_ready", {31'd0, req_ready_o}, 32'd1);
        sb_resp();
        sb_push(vc);
        cyc();
        exp_count++;
        req_valid_i = 1'b0;
        chk("b2b_busy", {31'd0, busy_o}, 32'd1);
        chk("b2b_valid_low", {31'd0, resp_valid_o}, 32'd0);
        chk("b2b_op_count", op_count_o, exp_count);
        chk("b2b_alu_in0", alu_in0_o, vc.in0);
        cyc();
        chk("b2b_resp_valid", {31'd0, resp_valid_o}, 32'd1);
        sb_resp();
        cyc();
        exp_count++;
        chk("b2b_op_count2", op_count_o, exp_count);

        // Flush in the third EXEC cycle of a lat=5 op.
        vf = '{32'h1111_1111, 32'h2222_2222, 32'd0, 16'h0060, 5'd0, 5'd0, 3'd0, 4'd5, 5'd4, 32'h3333_3333};
        drive_req(vf);
        req_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        cyc();
        cyc();
        chk("flush_pre_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_ready", {31'd0, req_ready_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid_o) seen = 1;
            cyc();
        end
        chk("flush_no_resp", seen, 32'd0);
        chk("flush_op_count", op_count_o, exp_count);

        // Flush coincident with a request in IDLE must block the accept.
        req_in0_i   = 32'hDEAD_BEEF;
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        #1 chk("flush_idle_ready", {31'd0, req_ready_o}, 32'd0);
        cyc();
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("flush_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_alu_retain", alu_in0_o, vf.in0);

        // Flush beats a simultaneous response handshake in DONE.
        vg = '{32'h0000_00FF, 32'h0000_0F00, 32'd0, 16'h0070, 5'd0, 5'd0, 3'd0, 4'd0, 5'd2, 32'h0000_0FFF};
        drive_req(vg);
        req_valid_i  = 1'b1;
        resp_ready_i = 1'b0;
        cyc();
        req_valid_i = 1'b0;
        cyc();
        chk("fdone_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("fdone_data", resp_data_o, vg.exp);
        resp_ready_i = 1'b1;
        flush_i      = 1'b1;
        #1 chk("fdone_ready", {31'd0, req_ready_o}, 32'd0);
        cyc();
        flush_i = 1'b0;
        chk("fdone_dropped", {31'd0, resp_valid_o}, 32'd0);
        chk("fdone_op_count", op_count_o, exp_count);

        // Asynchronous reset in EXEC cycle 8 of a max-latency op.
        vm = '{32'h7F7F_7F7F, 32'h0101_0101, 32'd0, 16'h0080, 5'd0, 5'd0, 3'd0, 4'd15, 5'd30, 32'h7E7E_7E7E};
        drive_req(vm);
        req_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        k = 1;
        while (k < 8) begin
            cyc();
            k++;
        end
        chk("arst_pre_busy", {31'd0, busy_o}, 32'd1);
        chk("arst_pre_op_count", op_count_o, exp_count);
        #2 reset_i = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("arst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("arst_op_count", op_count_o, 32'd0);
        chk("arst_alu_in0", alu_in0_o, 32'd0);
        chk("arst_resp_data", resp_data_o, 32'd0);
        chk("arst_resp_tag", {27'd0, resp_tag_o}, 32'd0);
        cyc();
        reset_i   = 1'b1;
        exp_count = '0;
        sb.delete();
        cyc();
        chk("arst_stays_idle", {31'd0, busy_o}, 32'd0);

        run_vec(vecs[0]);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/riscv_32f_fp_issue_ctrl.md
Name: riscv_32F_fp_issue_ctrl

Overview:
- Single-outstanding issue/sequencing controller placed between the FP decode stage and the pipelined RV32F ALU.
- Accepts one FP operation per valid/ready handshake and registers its operands and control fields onto the ALU inputs.
- Holds them stable for the operation's latency, then captures the ALU result and presents it to writeback with its destination tag.
- Replaces fixed stall-count logic in the core with an explicit handshake, and supports flush on pipeline redirect.

Parameters:
TAG_W, 5, width of destination register tag
LAT_W, 4, width of latency field (max latency 2^LAT_W-1)

Ports:
clock_i  in  1  core/float clock
reset_i  in  1  asynchronous, active-low reset
req_valid_i  in  1  decode presents an FP op
req_ready_o  out  1  controller can accept an op this cycle
req_in0_i / req_in1_i / req_in2_i  in  32 each  source operands
req_encoding_i  in  16  instruction encoding class
req_func5_i  in  5  func5 field
req_fsrc2_i  in  5  rs2 field (conversion select)
req_rm_i  in  3  rm/func3 field
req_lat_i  in  LAT_W  ALU pipeline latency of this op in clocks (0 = combinational result)
req_tag_i  in  TAG_W  destination register index
alu_in0_o / alu_in1_o / alu_in2_o  out  32 each  registered operands to ALU
alu_encoding_o  out  16  registered encoding to ALU
alu_func5_o  out  5  registered func5 to ALU
alu_fsrc2_o  out  5  registered fsrc2 to ALU
alu_rm_o  out  3  registered rm to ALU
alu_result_i  in  32  ALU out_o
resp_valid_o  out  1  result available
resp_ready_i  in  1  writeback accepts result
resp_data_o  out  32  captured result
resp_tag_o  out  TAG_W  destination tag of result
flush_i  in  1  kill any in-flight or pending op
busy_o  out  1  state != IDLE
op_count_o  out  32  completed-op counter (wraps)

Behaviour:
- States: IDLE, EXEC, DONE. Reset drives state IDLE; all registered outputs, the latency counter and op_count_o go to 0.
- Signal values after reset: req_ready_o=1, resp_valid_o=0, busy_o=0.
- req_ready_o is combinational: (state==IDLE) or (state==DONE and resp_ready_i), and is forced 0 when flush_i=1.
- Accept: a request is accepted on an edge where req_valid_i and req_ready_o are both 1.
  - All req_* fields are registered onto alu_*_o and the tag register.
  - cnt is loaded with req_lat_i; state goes to EXEC.
- EXEC:
  - alu_*_o are held constant.
  - If cnt!=0, cnt decrements.
  - If cnt==0, alu_result_i is captured into resp_data_o and state goes to DONE.
  - EXEC therefore lasts req_lat_i+1 cycles. With the accept edge at end of cycle T, resp_valid_o is first high in cycle T+req_lat_i+2.
- DONE:
  - resp_valid_o=1; resp_data_o and resp_tag_o are held stable until the handshake.
  - On resp_valid_o and resp_ready_i, op_count_o increments.
  - Next state is EXEC if a new request is accepted in the same cycle (back-to-back issue), otherwise IDLE.
- alu_*_o keep their last values in IDLE and DONE; they change only on accept.
- Flush:
  - flush_i=1 forces state IDLE on the next edge from any state; cnt is cleared.
  - A response pending in DONE is dropped and does not count.
  - flush_i has priority over a simultaneous accept or response handshake.
  - alu_*_o retain their values.
- req_lat_i at its maximum (all ones) gives 2^LAT_W EXEC cycles; the counter never wraps.
- Reset asserted mid-EXEC or mid-DONE returns the controller immediately (asynchronously) to the reset values.
- op_count_o wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset then idle: reset_i=0 for 3 cycles, release -> req_ready_o=1, resp_valid_o=0, busy_o=0, op_count_o=0.
- Combinational op: FSGNJ with in0=0x3F800000, in1=0x80000000, lat=0, tag=7, resp_ready_i=1 -> resp_valid_o high exactly 2 cycles after the accept cycle; resp_data_o=0xBF800000, resp_tag_o=7; op_count_o=1.
- Pipelined op: FDIV lat=10, in0=0x40400000, in1=0x3F800000 -> alu_*_o stable for 11 cycles; resp_valid_o first high at T+12 with data 0x40400000; req_ready_o=0 throughout EXEC.
- Writeback backpressure: resp_ready_i=0 for 5 cycles in DONE -> resp_data_o and resp_tag_o unchanged and req_ready_o=0. Then resp_ready_i=1 with req_valid_i=1 -> new op accepted the same edge, state EXEC, op_count_o increments by 1.
- Flush: flush_i pulsed in the 3rd EXEC cycle of a lat=5 op -> IDLE next cycle; no resp_valid_o ever; op_count_o unchanged. Flush coincident with req_valid_i in IDLE -> no accept.
- Max latency: lat=15 -> 16 EXEC cycles, resp at T+17; an async reset asserted in EXEC cycle 8 -> outputs at reset values immediately.
